spi_slave: RTL

SPI responder for the far end of the SPI_master link. It samples an externally driven serial clock, select and MOSI line by oversampling them on the local system clock. Each full-duplex 8-bit frame delivers one received byte to local logic and shifts out one byte that local logic preloaded into a one-entry transmit buffer. Bit order matches the master: MOSI arrives LSB first, and MISO is sent MSB first.

---
 rtl/spi_pkg.sv | 25 ++
 rtl/spi_slave_if.sv | 28 ++
 rtl/spi_sync.sv | 31 +++
 rtl/spi_slave.sv | 138 +++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode decoding, frame width and responder state encoding.
package spi_pkg;

    localparam int unsigned SPI_MODE_0 = 0;
    localparam int unsigned SPI_MODE_1 = 1;
    localparam int unsigned SPI_MODE_2 = 2;
    localparam int unsigned SPI_MODE_3 = 3;

    localparam int unsigned FRAME_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDone
    } spi_state_e;

    function automatic logic spi_cpol(input int unsigned mode);
        return (mode == SPI_MODE_2) || (mode == SPI_MODE_3);
    endfunction

    function automatic logic spi_cpha(input int unsigned mode);
        return (mode == SPI_MODE_1) || (mode == SPI_MODE_3);
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// SPI responder signal bundle: serial pins from the master plus the local TX/RX handshake.
interface spi_slave_if;
    import spi_pkg::*;

    logic                  i_SCLK;
    logic                  i_SS_n;
    logic                  i_MOSI;
    logic [FRAME_BITS-1:0] i_TX_DATA;
    logic                  i_TX_VALID;
    logic                  o_TX_READY;
    logic [FRAME_BITS-1:0] o_RX_DATA;
    logic                  o_RX_VALID;
    logic                  o_TX_UNDERRUN;
    logic                  o_ABORT;
    logic                  o_BUSY;
    logic                  o_MISO_EN;  // pad enable for the tristated MISO pin

    modport slave (
        input  i_SCLK, i_SS_n, i_MOSI, i_TX_DATA, i_TX_VALID,
        output o_TX_READY, o_RX_DATA, o_RX_VALID, o_TX_UNDERRUN, o_ABORT, o_BUSY, o_MISO_EN
    );

    modport master (
        output i_SCLK, i_SS_n, i_MOSI, i_TX_DATA, i_TX_VALID,
        input  o_TX_READY, o_RX_DATA, o_RX_VALID, o_TX_UNDERRUN, o_ABORT, o_BUSY, o_MISO_EN
    );

endinterface

// File: rtl/spi_sync.sv
// Two-flop synchroniser with a previous-value register for rise/fall detection.
module spi_sync #(
    parameter logic ResetVal = 1'b0
) (
    input  logic P_CLK,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge P_CLK or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
            prev_q <= ResetVal;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled serial pins, one-entry TX holding register, LSB-first RX, MSB-first TX.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SPI_MODE = 0
) (
    input  logic        P_CLK,
    input  logic        reset_n,
    spi_slave_if.slave  bus,
    output wire         o_MISO
);

    localparam logic            Cpol     = spi_cpol(SPI_MODE);
    localparam logic            Cpha     = spi_cpha(SPI_MODE);
    localparam logic [3:0]      FrameCnt = 4'(FRAME_BITS);

    logic sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
    logic unused_sclk_q, unused_ss_q, unused_mosi_rise, unused_mosi_fall;

    spi_sync #(.ResetVal(Cpol)) u_sync_sclk (
        .P_CLK(P_CLK), .reset_n(reset_n), .d(bus.i_SCLK),
        .q(unused_sclk_q), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync #(.ResetVal(1'b1)) u_sync_ss (
        .P_CLK(P_CLK), .reset_n(reset_n), .d(bus.i_SS_n),
        .q(unused_ss_q), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync #(.ResetVal(1'b0)) u_sync_mosi (
        .P_CLK(P_CLK), .reset_n(reset_n), .d(bus.i_MOSI),
        .q(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = Cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = Cpol ? sclk_rise : sclk_fall;
    assign sample_edge = Cpha ? trail_edge : lead_edge;
    assign shift_edge  = Cpha ? lead_edge : trail_edge;

    spi_state_e            state_q;
    logic [FRAME_BITS-1:0] tx_hold_q, tx_shift_q, rx_shift_q, rx_data_q;
    logic                  tx_full_q, skip_shift_q, miso_q, miso_oe_q;
    logic                  rx_valid_q, underrun_q, abort_q;
    logic [3:0]            bit_cnt_q;
    logic                  tx_load, tx_copy;

    assign tx_load = bus.i_TX_VALID && !tx_full_q;
    assign tx_copy = (state_q == StIdle) && ss_fall;

    // A load coinciding with a copy still finds the register empty, so the copy underruns.
    always_ff @(posedge P_CLK or negedge reset_n) begin
        if (!reset_n) begin
            tx_hold_q <= '0;
            tx_full_q <= 1'b0;
        end else if (tx_load) begin
            tx_hold_q <= bus.i_TX_DATA;
            tx_full_q <= 1'b1;
        end else if (tx_copy) begin
            tx_full_q <= 1'b0;
        end
    end

    always_ff @(posedge P_CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            bit_cnt_q    <= '0;
            skip_shift_q <= 1'b0;
            miso_q       <= 1'b0;
            miso_oe_q    <= 1'b0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
            abort_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (ss_fall) begin
                        tx_shift_q   <= tx_full_q ? tx_hold_q : '0;
                        miso_q       <= tx_full_q ? tx_hold_q[FRAME_BITS-1] : 1'b0;
                        underrun_q   <= !tx_full_q;
                        bit_cnt_q    <= '0;
                        skip_shift_q <= Cpha;
                        miso_oe_q    <= 1'b1;
                        state_q      <= StActive;
                    end
                end
                StActive: begin
                    if (bit_cnt_q == FrameCnt) begin
                        rx_data_q  <= rx_shift_q;
                        rx_valid_q <= 1'b1;
                        miso_oe_q  <= !ss_rise;
                        state_q    <= ss_rise ? StIdle : StDone;
                    end else if (ss_rise) begin
                        abort_q   <= 1'b1;
                        miso_oe_q <= 1'b0;
                        state_q   <= StIdle;
                    end else begin
                        if (sample_edge) begin
                            rx_shift_q[bit_cnt_q[2:0]] <= mosi_s;
                            bit_cnt_q                  <= bit_cnt_q + 4'd1;
                        end
                        if (shift_edge) begin
                            if (skip_shift_q) begin
                                skip_shift_q <= 1'b0;
                            end else begin
                                tx_shift_q <= {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                                miso_q     <= tx_shift_q[FRAME_BITS-2];
                            end
                        end
                    end
                end
                StDone: begin
                    if (ss_rise) begin
                        miso_oe_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_MISO            = miso_oe_q ? miso_q : 1'bz;
    assign bus.o_MISO_EN     = miso_oe_q;
    assign bus.o_TX_READY    = !tx_full_q;
    assign bus.o_RX_DATA     = rx_data_q;
    assign bus.o_RX_VALID    = rx_valid_q;
    assign bus.o_TX_UNDERRUN = underrun_q;
    assign bus.o_ABORT       = abort_q;
    assign bus.o_BUSY        = (state_q != StIdle);

endmodule
